// File: rtl/rx_pkg.sv
// Shared definitions for the serial receiver frame path: frame sequencer
// states, default framing constants used by the capture registers and the
// CRC checker, and a saturating statistics increment.
package rx_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CRC     = 2'd2,
        CHECK   = 2'd3
    } rx_state_e;

    localparam int         RX_SYNC_BITS    = 8;
    localparam logic [7:0] RX_SYNC_WORD    = 8'h03;
    localparam int         RX_PAYLOAD_BITS = 96;
    localparam int         RX_CRC_BITS     = 16;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_sync_det.sv
// Sync word hunter. Keeps the most recent SYNC_BITS-1 received bits and
// compares them, together with the bit on the input right now, against the
// sync pattern, so a match is flagged on the edge that samples the last
// sync bit. The oldest bit of a full SYNC_BITS window falls out on the
// very shift that would store it, so only SYNC_BITS-1 history bits are kept.
module rx_sync_det
    import rx_pkg::*;
#(
    parameter int                   SYNC_BITS = RX_SYNC_BITS,
    parameter logic [SYNC_BITS-1:0] SYNC_WORD = RX_SYNC_WORD
) (
    input  logic i_clck,
    input  logic i_clr,
    input  logic i_shift,
    input  logic i_x,
    output logic o_match
);

    localparam int HIST_W = SYNC_BITS - 1;

    logic [HIST_W-1:0]    r_hist;
    logic [SYNC_BITS-1:0] w_next;

    assign w_next  = {r_hist, i_x};
    assign o_match = (w_next == SYNC_WORD);

    // History register: cleared on request, otherwise shifts x in at the LSB.
    always_ff @(posedge i_clck) begin
        if (i_clr) begin
            r_hist <= {HIST_W{1'b0}};
        end else if (i_shift) begin
            r_hist <= w_next[HIST_W-1:0];
        end else begin
            r_hist <= r_hist;
        end
    end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Frame sequencer for the serial receiver. Hunts the sync word, then steps
// through the payload/FEC field and the CRC field driving the capture
// register shift enables, gives the external CRC checker one cycle to
// settle, and records the verdict plus saturating frame/error statistics.
module rx_frame_ctrl
    import rx_pkg::*;
#(
    parameter int                   SYNC_BITS    = RX_SYNC_BITS,
    parameter logic [SYNC_BITS-1:0] SYNC_WORD    = RX_SYNC_WORD,
    parameter int                   PAYLOAD_BITS = RX_PAYLOAD_BITS,
    parameter int                   CRC_BITS     = RX_CRC_BITS
) (
    input  logic       clck,
    input  logic       start,
    input  logic       x,
    input  logic       abort,
    input  logic       crc_zero,
    output logic       pay_sh,
    output logic       crc_sh,
    output logic       crc_calc_en,
    output logic       crc_clr,
    output logic       busy,
    output logic       done,
    output logic       status,
    output logic [7:0] frame_cnt,
    output logic [7:0] err_cnt
);

    localparam int MAX_BITS = (PAYLOAD_BITS > CRC_BITS) ? PAYLOAD_BITS : CRC_BITS;
    localparam int CNT_W    = $clog2(MAX_BITS);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAYLOAD_BITS - 1);
    localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(CRC_BITS - 1);

    rx_state_e        r_state;
    rx_state_e        w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_match;
    logic             w_complete;
    logic             w_sync_clr;
    logic             r_done;
    logic             r_status;
    logic [7:0]       r_frame_cnt;
    logic [7:0]       r_err_cnt;

    // The hunter only runs in HUNT; holding it clear elsewhere guarantees
    // every hunt starts from an all-zero history.
    assign w_sync_clr = start | (r_state != HUNT);

    rx_sync_det #(
        .SYNC_BITS (SYNC_BITS),
        .SYNC_WORD (SYNC_WORD)
    ) u_sync_det (
        .i_clck  (clck),
        .i_clr   (w_sync_clr),
        .i_shift (r_state == HUNT),
        .i_x     (x),
        .o_match (w_match)
    );

    // State register.
    always_ff @(posedge clck) begin
        if (start) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; abort beats both field completion and frame completion.
    always_comb begin
        w_next_state = r_state;
        w_complete   = 1'b0;
        case (r_state)
            HUNT: begin
                if (w_match) begin
                    w_next_state = PAYLOAD;
                end else begin
                    w_next_state = HUNT;
                end
            end
            PAYLOAD: begin
                if (abort) begin
                    w_next_state = HUNT;
                end else if (r_cnt == PAY_LAST) begin
                    w_next_state = CRC;
                end else begin
                    w_next_state = PAYLOAD;
                end
            end
            CRC: begin
                if (abort) begin
                    w_next_state = HUNT;
                end else if (r_cnt == CRC_LAST) begin
                    w_next_state = CHECK;
                end else begin
                    w_next_state = CRC;
                end
            end
            CHECK: begin
                if (abort) begin
                    w_next_state = HUNT;
                end else begin
                    w_next_state = HUNT;
                    w_complete   = 1'b1;
                end
            end
            default: begin
                w_next_state = HUNT;
            end
        endcase
    end

    // Bit counter: restarts on every state change, counts inside the fields.
    always_ff @(posedge clck) begin
        if (start) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_next_state != r_state) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if ((r_state == PAYLOAD) || (r_state == CRC)) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= {CNT_W{1'b0}};
        end
    end

    // Frame verdict, completion pulse and saturating statistics.
    always_ff @(posedge clck) begin
        if (start) begin
            r_done      <= 1'b0;
            r_status    <= 1'b0;
            r_frame_cnt <= 8'd0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_done <= w_complete;
            if (w_complete) begin
                r_status    <= crc_zero;
                r_frame_cnt <= sat_inc8(r_frame_cnt);
                if (!crc_zero) begin
                    r_err_cnt <= sat_inc8(r_err_cnt);
                end else begin
                    r_err_cnt <= r_err_cnt;
                end
            end else begin
                r_status    <= r_status;
                r_frame_cnt <= r_frame_cnt;
                r_err_cnt   <= r_err_cnt;
            end
        end
    end

    // Enables depend on state alone, so x never reaches an output combinationally.
    assign pay_sh      = (r_state == PAYLOAD);
    assign crc_sh      = (r_state == CRC);
    assign crc_calc_en = (r_state == PAYLOAD) || (r_state == CRC);
    assign crc_clr     = (r_state == HUNT);
    assign busy        = (r_state != HUNT);
    assign done        = r_done;
    assign status      = r_status;
    assign frame_cnt   = r_frame_cnt;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl. The driver builds whole frames (sync, random
// payload, random CRC bits, verdict) and queues the completion it expects;
// a monitor sampling 2 time units after each rising edge pops and checks it.
module tb_rx_frame_ctrl;
    import rx_pkg::*;

    logic       clck = 1'b0;
    logic       start = 1'b1;
    logic       x = 1'b0;
    logic       abort = 1'b0;
    logic       crc_zero = 1'b0;
    logic       pay_sh, crc_sh, crc_calc_en, crc_clr, busy, done, status;
    logic [7:0] frame_cnt, err_cnt;

    rx_frame_ctrl dut (
        .clck        (clck),
        .start       (start),
        .x           (x),
        .abort       (abort),
        .crc_zero    (crc_zero),
        .pay_sh      (pay_sh),
        .crc_sh      (crc_sh),
        .crc_calc_en (crc_calc_en),
        .crc_clr     (crc_clr),
        .busy        (busy),
        .done        (done),
        .status      (status),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 clck = ~clck;

    typedef struct {
        int edge_n;
        bit ok;
    } exp_t;

    exp_t     exp_q[$];
    int       total = 0;
    int       bad = 0;
    int       edge_no = 0;
    int       m_fc = 0;
    int       m_ec = 0;
    bit       m_st = 1'b0;
    int       pay_n = 0;
    int       crc_n = 0;
    bit       prev_busy = 1'b0;
    bit       stim_done = 1'b0;
    bit       mon_done = 1'b0;
    bit [7:0] hist = 8'd0;

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", nm, act, expv, edge_no);
        end
    endtask

    // Monitor / scoreboard.
    always begin
        exp_t e;
        @(posedge clck);
        edge_no = edge_no + 1;
        #2;
        if (start) begin
            m_fc = 0;
            m_ec = 0;
            m_st = 1'b0;
            exp_q.delete();
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_crc_clr", int'(crc_clr), 1);
            chk("rst_pay_sh", int'(pay_sh), 0);
            chk("rst_crc_sh", int'(crc_sh), 0);
            chk("rst_calc_en", int'(crc_calc_en), 0);
            chk("rst_status", int'(status), 0);
            chk("rst_frame_cnt", int'(frame_cnt), 0);
            chk("rst_err_cnt", int'(err_cnt), 0);
        end else begin
            if (exp_q.size() > 0 && exp_q[0].edge_n < edge_no) begin
                total++;
                bad++;
                $display("FAIL done_missing: got none expected done at edge %0d", exp_q[0].edge_n);
                void'(exp_q.pop_front());
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", int'(done), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_edge", edge_no, e.edge_n);
                    m_fc = (m_fc < 255) ? m_fc + 1 : 255;
                    if (!e.ok) m_ec = (m_ec < 255) ? m_ec + 1 : 255;
                    m_st = e.ok;
                    chk("status", int'(status), int'(m_st));
                    chk("frame_cnt", int'(frame_cnt), m_fc);
                    chk("err_cnt", int'(err_cnt), m_ec);
                    chk("pay_sh_cycles", pay_n, RX_PAYLOAD_BITS);
                    chk("crc_sh_cycles", crc_n, RX_CRC_BITS);
                end
            end else begin
                chk("status_hold", int'(status), int'(m_st));
                chk("frame_cnt_hold", int'(frame_cnt), m_fc);
                chk("err_cnt_hold", int'(err_cnt), m_ec);
            end
            if (abort && prev_busy) chk("abort_exit", int'(busy), 0);
            chk("calc_en", int'(crc_calc_en), int'(pay_sh | crc_sh));
            chk("crc_clr_hunt", int'(crc_clr), int'(!busy));
        end
        if (!busy) begin
            pay_n = 0;
            crc_n = 0;
        end else begin
            pay_n += int'(pay_sh);
            crc_n += int'(crc_sh);
        end
        prev_busy = busy;
        if (stim_done && !mon_done) begin
            chk("queue_drained", exp_q.size(), 0);
            mon_done = 1'b1;
        end
    end

    function automatic bit rb();
        return $urandom_range(0, 1) != 0;
    endfunction

    task automatic step(input bit b, input bit ab, input bit cz, input bit st);
        @(negedge clck);
        x        = b;
        abort    = ab;
        crc_zero = cz;
        start    = st;
    endtask

    // Random hunt bits that never complete the sync pattern (history starts at 0).
    task automatic idle(input int n);
        bit b;
        for (int i = 0; i < n; i++) begin
            b = rb();
            if ({hist[6:0], b} == RX_SYNC_WORD) b = 1'b0;
            hist = {hist[6:0], b};
            step(b, ($urandom_range(0, 3) == 0), rb(), 1'b0);
        end
    endtask

    // abort_at: payload index to abort on, 200 = abort in CHECK, -1 none.
    // start_at: CRC bit index to reset on, -1 none.
    task automatic send_frame(input bit ok, input int abort_at, input int start_at);
        logic [7:0] sw;
        int         e0;
        sw = RX_SYNC_WORD;
        for (int i = 0; i < 8; i++) step(sw[7-i], 1'b0, rb(), 1'b0);
        e0 = edge_no + 1;
        for (int i = 0; i < RX_PAYLOAD_BITS; i++) begin
            if (i == abort_at) begin
                step(rb(), 1'b1, rb(), 1'b0);
                hist = 8'd0;
                return;
            end
            step(rb(), 1'b0, rb(), 1'b0);
        end
        for (int i = 0; i < RX_CRC_BITS; i++) begin
            if (i == start_at) begin
                step(rb(), 1'b0, rb(), 1'b1);
                hist = 8'd0;
                return;
            end
            step(rb(), 1'b0, rb(), 1'b0);
        end
        if (abort_at == 200) begin
            step(rb(), 1'b1, !ok, 1'b0);
            hist = 8'd0;
            return;
        end
        exp_q.push_back('{edge_n: e0 + 113, ok: ok});
        step(rb(), 1'b0, ok, 1'b0);
        hist = 8'd0;
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b0, 1'b1);
        hist = 8'd0;
        idle(20);
        send_frame(1'b1, -1, -1);
        send_frame(1'b0, -1, -1);
        send_frame(1'b1, -1, -1);
        idle(3);
        send_frame(1'b1, 40, -1);
        idle(5);
        send_frame(1'b1, -1, -1);
        send_frame(1'b1, 200, -1);
        idle(2);
        send_frame(1'b1, -1, -1);
        send_frame(1'b1, -1, 5);
        idle(4);
        send_frame(1'b0, -1, -1);
        for (int k = 0; k < 12; k++) begin
            idle($urandom_range(0, 6));
            send_frame(rb(), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 95) : -1, -1);
        end
        for (int k = 0; k < 260; k++) send_frame(1'b0, -1, -1);
        idle(130);
        stim_done = 1'b1;
        repeat (5) @(posedge clck);
        if (!mon_done) begin
            $display("FAIL monitor_stall: got no final check expected one");
            $fatal(1, "monitor did not finish");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_frame_ctrl.md
# rx_frame_ctrl

Frame sequencer for the serial receiver datapath. Hunts a fixed sync word in the 1-bit-per-clock input stream, then drives shift enables for the 96-bit payload/FEC capture register and the 16-bit CRC capture register. It sequences the external CRC checker and reports a per-frame pass/fail status. It sits between the serial input pin and the receiver's capture/decode datapath, and adds frame and error statistics.

## Interface
- SYNC_BITS, 8, sync word length
- SYNC_WORD, 8'h03, sync pattern, MSB received first
- PAYLOAD_BITS, 96, payload/FEC field length
- CRC_BITS, 16, CRC field length
- clck  in  1  clock; all logic on rising edge
- start  in  1  reset; synchronous, active-high
- x  in  1  serial data bit, one per clck
- abort  in  1  cancel current frame, return to hunt
- crc_zero  in  1  checker residue is zero; valid the cycle after last crc_sh
- pay_sh  out  1  payload register shifts in x at this edge
- crc_sh  out  1  CRC register shifts in x at this edge
- crc_calc_en  out  1  CRC checker consumes x at this edge
- crc_clr  out  1  CRC checker clear
- busy  out  1  frame in progress (not HUNT)
- done  out  1  one-cycle frame-complete pulse
- status  out  1  last frame CRC good; held until next done
- frame_cnt  out  8  frames completed, saturating
- err_cnt  out  8  frames with bad CRC, saturating

## Operation
- States: HUNT, PAYLOAD, CRC, CHECK.
- HUNT:
  - sync shift register sreg (SYNC_BITS) shifts x in at LSB each edge.
  - Match test uses the next value {sreg[SYNC_BITS-2:0], x}. On match, go to PAYLOAD and clear the bit counter.
  - crc_clr=1 throughout HUNT.
- PAYLOAD:
  - pay_sh=crc_calc_en=1 combinationally.
  - Bit counter counts 0..PAYLOAD_BITS-1. At the edge where count=PAYLOAD_BITS-1, go to CRC and clear the counter.
- CRC:
  - crc_sh=crc_calc_en=1.
  - At count=CRC_BITS-1, go to CHECK.
- CHECK:
  - All shift enables 0.
  - At the next edge: status<=crc_zero, done<=1, frame_cnt+1 (saturate at 255), err_cnt+1 if crc_zero=0 (saturate 255).
  - Go to HUNT and clear sreg to 0.
- x is ignored outside HUNT/PAYLOAD/CRC. Sync bits arriving during CHECK are not counted.
- abort=1 in any non-HUNT state: go to HUNT and clear sreg/counter next edge. No done, counters and status unchanged. abort in HUNT has no effect.
- abort has priority over completion in CHECK.
- Back-to-back frames are supported; the next sync may begin with the first bit sampled in HUNT.
- Bit counter width is $clog2(max(PAYLOAD_BITS,CRC_BITS)).

## Timing
- Reset values (start=1 at an edge): state HUNT, sreg 0, counter 0, done 0, status 0, frame_cnt 0, err_cnt 0.
  - Combinational outputs follow state: pay_sh 0, crc_sh 0, crc_calc_en 0, crc_clr 1, busy 0.
- start wins over all other inputs. Reset mid-frame discards the frame with no done.
- Let E0 be the edge sampling the last sync bit:
  - Payload bits are sampled on E1..E96 (pay_sh high during the cycles before those edges).
  - CRC bits are sampled on E97..E112.
  - CHECK occupies the cycle before E113. crc_zero is sampled at E113.
  - done is high for the single cycle after E113. Earliest next sync bit is sampled at E114.
- Total frame latency, last sync bit to done: 113 clck cycles (with defaults).
- done and status are registered. Enables and busy are decoded from state only; there is no combinational path from x.

## Structure
- Shared package rx_pkg:
  - state enum (HUNT, PAYLOAD, CRC, CHECK)
  - default SYNC_WORD, PAYLOAD_BITS, CRC_BITS constants, shared with the capture registers and CRC checker.
- Sub-module rx_sync_det: sreg plus next-value compare, with clear input and match output.
- The FSM, bit counter and saturating statistic counters stay in rx_frame_ctrl.

## Test plan
- Reset, then 20 random bits without 00000011 -> busy 0, crc_clr 1, no done, counters 0.
- Sync 00000011, 96 payload bits, 16 CRC bits, crc_zero=1 at E113 -> pay_sh high exactly 96 cycles, crc_sh exactly 16, done pulse at E113+1, status 1, frame_cnt 1, err_cnt 0.
- Same frame with crc_zero=0 -> status 0, err_cnt 1. Then a good frame sent back-to-back (sync starting at E114) -> done again, status 1, frame_cnt 2.
- abort asserted at payload bit 40 -> back to HUNT next edge, no done, counters unchanged. The following frame completes normally.
- start asserted during the CRC field -> all outputs at reset values next cycle, frame_cnt 0.
- 260 bad-CRC frames -> frame_cnt and err_cnt saturate at 255 without wrapping.
